// File: rtl/binop_arbiter_if.sv
// rtl/binop_arbiter_if.sv - issue-lane request bus and result bus of the shared bitwise unit
interface binop_arbiter_if #(
  parameter int OPERANDSIZE = 64,
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
);
  logic [NREQ-1:0]             req_valid;
  logic [2*NREQ-1:0]           req_op;
  logic [NREQ*OPERANDSIZE-1:0] req_a;
  logic [NREQ*OPERANDSIZE-1:0] req_b;
  logic [NREQ-1:0]             req_ready;
  logic                        res_valid;
  logic [OPERANDSIZE-1:0]      res_data;
  logic [IDW-1:0]              res_id;
  logic                        res_err;
  logic                        res_ready;

  modport master (
    output req_valid, req_op, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id, res_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id, res_err
  );
endinterface

// File: rtl/binop_arbiter.sv
// rtl/binop_arbiter.sv - round-robin shared XOR/AND/OR unit with a registered single-entry result stage
// Optional stall counter port perf_stall_cnt is built when BINOP_ARB_PERF_EN is defined.
module binop_arbiter #(
  parameter int OPERANDSIZE = 64,
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic clk,
  input  logic rst,
`ifdef BINOP_ARB_PERF_EN
  output logic [31:0] perf_stall_cnt,
`endif
  binop_arbiter_if.slave bus
);

  logic [IDW-1:0]         rr_ptr;
  logic [IDW-1:0]         gnt_idx;
  logic [IDW-1:0]         ptr_next;
  logic [IDW:0]           cand;
  logic                   found;
  logic                   gnt_any;
  logic                   avail;
  logic [1:0]             gnt_op;
  logic [OPERANDSIZE-1:0] gnt_a;
  logic [OPERANDSIZE-1:0] gnt_b;
  logic [OPERANDSIZE-1:0] gnt_res;

  logic                   res_valid_q;
  logic [OPERANDSIZE-1:0] res_data_q;
  logic [IDW-1:0]         res_id_q;
  logic                   res_err_q;

  // Search upward from rr_ptr, wrapping at NREQ (not at 2**IDW).
  always_comb begin
    avail   = !res_valid_q || bus.res_ready;
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!found && bus.req_valid[cand[IDW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[IDW-1:0];
      end
    end
    gnt_any = found && avail && !rst;
  end

  always_comb begin
    bus.req_ready = '0;
    if (gnt_any) bus.req_ready[gnt_idx] = 1'b1;
  end

  assign gnt_op   = bus.req_op[int'(gnt_idx)*2 +: 2];
  assign gnt_a    = bus.req_a[int'(gnt_idx)*OPERANDSIZE +: OPERANDSIZE];
  assign gnt_b    = bus.req_b[int'(gnt_idx)*OPERANDSIZE +: OPERANDSIZE];
  assign ptr_next = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    case (gnt_op)
      2'b00:   gnt_res = gnt_a ^ gnt_b;
      2'b01:   gnt_res = gnt_a & gnt_b;
      2'b10:   gnt_res = gnt_a | gnt_b;
      default: gnt_res = '0;
    endcase
  end

  // A grant overwrites the stage even while it drains, giving one op per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      res_err_q   <= 1'b0;
      rr_ptr      <= '0;
    end else if (gnt_any) begin
      res_valid_q <= 1'b1;
      res_data_q  <= gnt_res;
      res_id_q    <= gnt_idx;
      res_err_q   <= (gnt_op == 2'b11);
      rr_ptr      <= ptr_next;
    end else if (bus.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_err   = res_err_q;

`ifdef BINOP_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
    end else if (|bus.req_valid && !gnt_any && perf_stall_cnt != 32'hFFFF_FFFF) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_binop_arbiter.sv
// tb/tb_binop_arbiter.sv - self-checking bench for binop_arbiter with a cycle-level reference model
module tb_binop_arbiter;
  localparam int W = 64;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  binop_arbiter_if #(.OPERANDSIZE(W), .NREQ(N)) bus ();

`ifdef BINOP_ARB_PERF_EN
  logic [31:0] perf;
  binop_arbiter #(.OPERANDSIZE(W), .NREQ(N)) dut (
    .clk(clk), .rst(rst), .perf_stall_cnt(perf), .bus(bus));
`else
  binop_arbiter #(.OPERANDSIZE(W), .NREQ(N)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'b00:   return a ^ b;
      2'b01:   return a & b;
      2'b10:   return a | b;
      default: return '0;
    endcase
  endfunction

  task automatic set_lane(input int i, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_op[i*2 +: 2] = op;
    bus.req_a[i*W +: W]  = a;
    bus.req_b[i*W +: W]  = b;
  endtask

  // Reference model: holds what the result stage must contain; grant is recomputed from rules.
  bit          m_valid;
  logic [W-1:0] m_data;
  int          m_id;
  bit          m_err;
  int          m_ptr;
  longint      m_stall;

  always @(negedge clk) begin
    int g;
    logic [N-1:0] exp_rdy;
    if (rst) begin
      chk("m_rst_ready", bus.req_ready, 0);
      chk("m_rst_valid", bus.res_valid, 0);
      chk("m_rst_data", bus.res_data, 0);
      chk("m_rst_id", bus.res_id, 0);
      chk("m_rst_err", bus.res_err, 0);
      m_valid = 0; m_data = '0; m_id = 0; m_err = 0; m_ptr = 0; m_stall = 0;
`ifdef BINOP_ARB_PERF_EN
      chk("m_rst_perf", perf, 0);
`endif
    end else begin
      g = -1;
      if (!m_valid || bus.res_ready)
        for (int k = 0; k < N; k++)
          if (g < 0 && bus.req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("m_req_ready", bus.req_ready, exp_rdy);
      chk("m_res_valid", bus.res_valid, m_valid);
      chk("m_res_data", bus.res_data, m_data);
      chk("m_res_id", bus.res_id, m_id);
      chk("m_res_err", bus.res_err, m_err);
`ifdef BINOP_ARB_PERF_EN
      chk("m_perf", perf, m_stall);
`endif
      if (g >= 0) begin
        m_valid = 1;
        m_data  = model_op(bus.req_op[g*2 +: 2], bus.req_a[g*W +: W], bus.req_b[g*W +: W]);
        m_id    = g;
        m_err   = (bus.req_op[g*2 +: 2] == 2'b11);
        m_ptr   = (g + 1) % N;
      end else if (bus.res_ready) begin
        m_valid = 0;
      end
      if (|bus.req_valid && g < 0 && m_stall < 64'hFFFF_FFFF) m_stall++;
    end
  end

  initial begin
    logic [W-1:0] sa, sb;
    logic [1:0]   sops [3];
    logic [W-1:0] sexp [3];
`ifdef BINOP_ARB_PERF_EN
    logic [31:0] cnt0;
`endif
    sa = 64'hF0F0_0000_FFFF_1234;
    sb = 64'h0FF0_FFFF_0000_1234;
    sops[0] = 2'b00; sexp[0] = 64'hFF00_FFFF_FFFF_0000;
    sops[1] = 2'b01; sexp[1] = 64'h00F0_0000_0000_1234;
    sops[2] = 2'b10; sexp[2] = 64'hFFF0_FFFF_FFFF_1234;

    bus.req_valid = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset in the middle of a held result
    bus.req_valid = 4'b0010;
    set_lane(1, 2'b00, 64'h55, 64'h0F);
    @(negedge clk); chk("pre_grant", bus.req_ready, 4'b0010);
    @(posedge clk); #1 bus.req_valid = '0; bus.res_ready = 1'b0;
    @(negedge clk); chk("pre_held", bus.res_valid, 1);
    @(posedge clk); #1 rst = 1'b1; bus.req_valid = 4'b0001; bus.res_ready = 1'b1;
    #1 chk("rst_async_valid", bus.res_valid, 0);
    chk("rst_async_ready", bus.req_ready, 0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0; bus.req_valid = '0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_out", {bus.res_valid, bus.res_err, bus.res_id, bus.res_data}, 0);
      chk("idle_ready", bus.req_ready, 0);
    end

    // round robin from a freshly reset pointer
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) set_lane(i, 2'b00, 64'h1111 * (i + 1), 64'hA5A5_0000_0000_0000);
    bus.req_valid = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("rr_grant", bus.req_ready, 64'd1 << (n % N));
      if (n > 0) begin
        chk("rr_valid", bus.res_valid, 1);
        chk("rr_id", bus.res_id, (n - 1) % N);
      end
      @(posedge clk); #1;
    end
    bus.req_valid = '0;

    // single ops on lane 2
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      set_lane(2, sops[s], sa, sb);
      bus.req_valid = 4'b0100;
      @(negedge clk); chk("single_grant", bus.req_ready, 4'b0100);
      @(posedge clk); #1 bus.req_valid = '0;
      @(negedge clk);
      chk("single_valid", bus.res_valid, 1);
      chk("single_data", bus.res_data, sexp[s]);
      chk("single_id", bus.res_id, 2);
      chk("single_err", bus.res_err, 0);
    end

    // backpressure: lane 1 result held while lanes 0 and 3 wait
    @(posedge clk); #1;
    set_lane(1, 2'b01, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F);
    bus.req_valid = 4'b0010;
    @(negedge clk); chk("bp_grant1", bus.req_ready, 4'b0010);
    @(posedge clk); #1;
    set_lane(0, 2'b00, 64'hAAAA, 64'h5555);
    set_lane(3, 2'b10, 64'h1000, 64'h0001);
    bus.req_valid = 4'b1001; bus.res_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_ready", bus.req_ready, 0);
      chk("bp_hold_data", bus.res_data, 64'h0204_0608_0A0C_0E00);
      chk("bp_hold_id", bus.res_id, 1);
      @(posedge clk); #1;
    end
    bus.res_ready = 1'b1;
    @(negedge clk); chk("bp_lane3", bus.req_ready, 4'b1000);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_lane0", bus.req_ready, 4'b0001);
    chk("bp_lane3_data", bus.res_data, 64'h1001);
    @(posedge clk); #1 bus.req_valid = '0;

    // reserved opcode
    @(posedge clk); #1;
    set_lane(0, 2'b11, '1, '1);
    bus.req_valid = 4'b0001;
    @(negedge clk); chk("rsv_grant", bus.req_ready, 4'b0001);
    @(posedge clk); #1 set_lane(0, 2'b00, 64'hFF, 64'h0F);
    @(negedge clk);
    chk("rsv_data", bus.res_data, 0);
    chk("rsv_err", bus.res_err, 1);
    chk("rsv_id", bus.res_id, 0);
    chk("rsv_next_grant", bus.req_ready, 4'b0001);
    @(posedge clk); #1 bus.req_valid = '0;
    @(negedge clk);
    chk("rsv_after_err", bus.res_err, 0);
    chk("rsv_after_data", bus.res_data, 64'hF0);

`ifdef BINOP_ARB_PERF_EN
    @(posedge clk); #1;
    bus.req_valid = 4'b0001;
    @(negedge clk); chk("perf_xfer", bus.req_ready, 4'b0001);
    cnt0 = perf;
    @(posedge clk); #1 bus.res_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus.req_valid = '0; bus.res_ready = 1'b1;
    @(negedge clk); chk("perf_delta", perf - cnt0, 5);
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/binop_arbiter.md
Name: binop_arbiter

Overview:
- Shares one bitwise logic unit (XOR/AND/OR) between NREQ VLIW issue lanes.
- Selects lanes round-robin and registers the result into a single-entry output stage with valid/ready backpressure.
- Sits between the issue-lane operand buses and the writeback path of the ALU cluster.
- Latency: 1 cycle from grant to res_valid.

Parameters:
- OPERANDSIZE, 64, operand/result width in bits.
- NREQ, 4, number of requesting lanes; legal range 2..16.
- IDW, $clog2(NREQ), width of the lane ID field (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NREQ  per-lane request valid.
- req_op  in  2*NREQ  per-lane opcode; lane i at [2*i +: 2]; 00=XOR, 01=AND, 10=OR, 11=reserved.
- req_a  in  NREQ*OPERANDSIZE  operand A; lane i at [i*OPERANDSIZE +: OPERANDSIZE].
- req_b  in  NREQ*OPERANDSIZE  operand B; same packing as req_a.
- req_ready  out  NREQ  per-lane grant/accept; one-hot or zero.
- res_valid  out  1  result register holds valid data.
- res_data  out  OPERANDSIZE  registered result.
- res_id  out  IDW  lane that produced res_data.
- res_err  out  1  result came from the reserved opcode.
- res_ready  in  1  downstream accepts the result.

Behaviour:
- Reset (async, rst=1): res_valid=0, res_data=0, res_id=0, res_err=0, rr_ptr=0.
  - req_ready is combinational and is 0 while rst=1.
  - Reset mid-transaction discards the held result without signalling it.
- Output availability: avail = !res_valid || res_ready (combinational).
- Grant:
  - If avail=1, the first lane with req_valid=1, searching upward from rr_ptr and wrapping NREQ-1 -> 0, gets req_ready[i]=1.
  - All other req_ready bits are 0.
  - If avail=0 or no lane is valid, req_ready=0.
- Transfer occurs on req_valid[i] && req_ready[i]. On the next clock edge:
  - res_valid=1.
  - res_data = op(a_i, b_i).
  - res_id = i.
  - res_err = (op==11).
  - rr_ptr = (i+1) mod NREQ.
- Reserved opcode 11: res_data = all zeros, res_err=1. It is consumed normally and never stalls.
- No grant while avail=1: res_valid clears if res_ready=1. rr_ptr is unchanged.
- Output hold: while res_valid=1 && res_ready=0, res_data, res_id and res_err stay stable and no lane is granted.
- Simultaneous drain and grant: with res_valid=1 and res_ready=1 in the same cycle as a grant, the new result replaces the old with no bubble. This gives full throughput of one op per cycle.
- Requester rules:
  - req_valid must not depend on req_ready.
  - Operands and opcode must stay stable while req_valid=1 and the lane is not granted.
  - The arbiter does not latch unaccepted requests.
- Fairness: any continuously valid lane is granted within NREQ transfers.
- Width rules:
  - All ops are bitwise; there is no carry or extension.
  - res_id is zero-extended into IDW bits.
- State: rr_ptr (IDW bits) plus the output register. rr_ptr never takes a value >= NREQ.

Optional Feature:
- Macro: BINOP_ARB_PERF_EN.
- Defined:
  - Adds output port perf_stall_cnt (32 bits).
  - Counts cycles where |req_valid=1 and no transfer occurs, i.e. backpressure stalls.
  - Saturates at 0xFFFFFFFF.
  - Reset to 0 by rst.
- Undefined: the port and the counter logic are absent. Functional behaviour is otherwise identical.

Test Plan:
- Reset/idle: assert rst mid-operation with res_valid=1. Expect res_valid=0, req_ready=0, rr_ptr=0 immediately. After release with no requests, all outputs stay 0.
- Single ops, lane 2 at NREQ=4, res_ready=1, a=0xF0F0_0000_FFFF_1234, b=0x0FF0_FFFF_0000_1234:
  - op 00 -> res_data=0xFF00_FFFF_FFFF_0000, res_id=2, one cycle after the grant.
  - op 01 -> res_data=0x00F0_0000_0000_1234.
  - op 10 -> res_data=0xFFF0_FFFF_FFFF_1234.
- Round-robin: all four lanes valid continuously, res_ready=1. Expect grant order 0,1,2,3,0,1 on consecutive cycles with res_valid held high.
- Backpressure: lane 1 issues, then res_ready=0 for 3 cycles while lanes 0 and 3 are valid. Expect req_ready=0 and res_data/res_id stable for those 3 cycles. When res_ready=1, lane 3 is granted the same cycle (rr_ptr=2), then lane 0.
- Reserved opcode: lane 0 op=11, a=b=all ones. Expect res_data=0, res_err=1, res_id=0. The next XOR request returns res_err=0.
- Perf counter (BINOP_ARB_PERF_EN): lane 0 valid, res_ready=0 for 5 cycles after one transfer. Expect perf_stall_cnt=5. Build without the macro and confirm the port is absent and all other scenarios pass.
